// File: rtl/clock_gate_ctrl.sv
// ---------------------------------------------------------------------------
// clock_gate_ctrl
//
// Run/halt/step controller for a CPU core clock enable. After reset is
// released the core is held in reset for RESET_CYCLES clocks. It then waits in
// HALTED until it is told to run freely or to execute a fixed-length step
// burst. A free-running 32-bit counter records every cycle in which the core
// was enabled.
//
// Parameters
//   RESET_CYCLES  cycles cpu_rst_n stays low after resetn release (1..65535)
//   STEP_W        width of step_count
//
// Ports
//   clock        in   single clock, rising edge
//   resetn       in   asynchronous active-low reset
//   run_req      in   pulse: start free-running execution (from HALTED)
//   halt_req     in   pulse: halt (from RUN/STEP, overrides all in HALTED)
//   step_req     in   pulse: start a step burst (from HALTED)
//   step_count   in   enabled cycles per burst, sampled with step_req; 0 -> 1
//   cpu_en       out  clock enable to the core (RUN or STEP)
//   cpu_rst_n    out  synchronous active-low reset to the core
//   halted       out  high while in HALTED
//   step_done    out  one-cycle pulse on the first HALTED cycle after a burst
//                     that ran to completion
//   state        out  RST_HOLD=0, HALTED=1, RUN=2, STEP=3
//   cycle_cnt    out  count of cycles with cpu_en=1, wraps at 2^32
// ---------------------------------------------------------------------------
module clock_gate_ctrl #(
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned STEP_W       = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic [STEP_W-1:0] step_count,
    output logic              cpu_en,
    output logic              cpu_rst_n,
    output logic              halted,
    output logic              step_done,
    output logic [1:0]        state,
    output logic [31:0]       cycle_cnt
);

    typedef enum logic [1:0] {
        StRstHold = 2'd0,
        StHalted  = 2'd1,
        StRun     = 2'd2,
        StStep    = 2'd3
    } state_e;

    // Hold counter value on the final RST_HOLD edge.
    localparam logic [15:0] HoldLast = 16'(RESET_CYCLES - 1);
    localparam logic [STEP_W-1:0] StepOne = STEP_W'(1);

    state_e            state_q, state_d;
    logic [15:0]       hold_q, hold_d;
    logic [STEP_W-1:0] burst_q, burst_d;
    logic              step_done_q, step_done_d;
    logic              cpu_en_q, cpu_en_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              halted_q, halted_d;
    logic [31:0]       cycle_cnt_q, cycle_cnt_d;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        burst_d     = burst_q;
        step_done_d = 1'b0;

        unique case (state_q)
            // Requests are ignored while the core is held in reset.
            StRstHold: begin
                if (hold_q == HoldLast) begin
                    state_d = StHalted;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 16'd1;
                end
            end

            // halt_req wins over step_req, which wins over run_req.
            StHalted: begin
                if (halt_req) begin
                    state_d = StHalted;
                end else if (step_req) begin
                    state_d = StStep;
                    burst_d = (step_count == '0) ? StepOne : step_count;
                end else if (run_req) begin
                    state_d = StRun;
                end
            end

            StRun: begin
                if (halt_req) begin
                    state_d = StHalted;
                end
            end

            // burst_q holds the enabled cycles still to run, including the
            // current one. An abort discards the remainder and suppresses
            // step_done, even if it lands on the last cycle.
            StStep: begin
                if (halt_req) begin
                    state_d = StHalted;
                    burst_d = '0;
                end else if (burst_q <= StepOne) begin
                    state_d     = StHalted;
                    burst_d     = '0;
                    step_done_d = 1'b1;
                end else begin
                    burst_d = burst_q - StepOne;
                end
            end

            default: begin
                state_d = StRstHold;
                hold_d  = '0;
                burst_d = '0;
            end
        endcase
    end

    // Moore outputs are decoded from the next state so that the registered
    // copies always agree with state_q.
    always_comb begin
        cpu_en_d    = (state_d == StRun) || (state_d == StStep);
        cpu_rst_n_d = (state_d != StRstHold);
        halted_d    = (state_d == StHalted);
    end

    // Counts the cycles the core was actually enabled.
    always_comb begin
        cycle_cnt_d = cpu_en_q ? (cycle_cnt_q + 32'd1) : cycle_cnt_q;
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StRstHold;
            hold_q      <= '0;
            burst_q     <= '0;
            step_done_q <= 1'b0;
            cpu_en_q    <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            halted_q    <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            burst_q     <= burst_d;
            step_done_q <= step_done_d;
            cpu_en_q    <= cpu_en_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            halted_q    <= halted_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign cpu_en    = cpu_en_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign halted    = halted_q;
    assign step_done = step_done_q;
    assign state     = state_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Bench for clock_gate_ctrl: directed scenarios followed by a randomized
// phase, all checked every cycle against a behavioural model.
module tb_clock_gate_ctrl;

    localparam int unsigned RC = 16;
    localparam int unsigned SW = 8;

    logic          clock = 1'b0;
    logic          resetn;
    logic          run_req, halt_req, step_req;
    logic [SW-1:0] step_count;
    logic          cpu_en, cpu_rst_n, halted, step_done;
    logic [1:0]    state;
    logic [31:0]   cycle_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    // Model: mode uses the published encoding (0 hold, 1 halted, 2 run, 3 step)
    int          m_state;
    int          m_hold;   // edges seen since reset release
    int          m_left;   // enabled cycles left in the burst
    bit          m_done;
    logic [31:0] m_cnt;

    always #5 clock = ~clock;

    clock_gate_ctrl #(
        .RESET_CYCLES (RC),
        .STEP_W       (SW)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .run_req    (run_req),
        .halt_req   (halt_req),
        .step_req   (step_req),
        .step_count (step_count),
        .cpu_en     (cpu_en),
        .cpu_rst_n  (cpu_rst_n),
        .halted     (halted),
        .step_done  (step_done),
        .state      (state),
        .cycle_cnt  (cycle_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_hold  = 0;
        m_left  = 0;
        m_done  = 1'b0;
        m_cnt   = 32'd0;
    endtask

    // One rising edge of the rules, using the inputs as they are now.
    task automatic model_edge();
        bit en;
        en     = (m_state == 2) || (m_state == 3);
        m_done = 1'b0;
        if (en) m_cnt = m_cnt + 32'd1;
        case (m_state)
            0: begin
                m_hold++;
                if (m_hold >= int'(RC)) m_state = 1;
            end
            1: begin
                if (halt_req) m_state = 1;
                else if (step_req) begin
                    m_state = 3;
                    m_left  = (step_count == 0) ? 1 : int'(step_count);
                end else if (run_req) m_state = 2;
            end
            2: if (halt_req) m_state = 1;
            default: begin
                if (halt_req) begin
                    m_state = 1;
                    m_left  = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_state = 1;
                        m_done  = 1'b1;
                    end
                end
            end
        endcase
    endtask

    task automatic check_all();
        chk("state",     32'(state),     32'(m_state));
        chk("cpu_en",    32'(cpu_en),    32'((m_state == 2) || (m_state == 3)));
        chk("cpu_rst_n", 32'(cpu_rst_n), 32'(m_state != 0));
        chk("halted",    32'(halted),    32'(m_state == 1));
        chk("step_done", 32'(step_done), 32'(m_done));
        chk("cycle_cnt", cycle_cnt,      m_cnt);
    endtask

    // Inputs change only at the falling edge; outputs checked 1 after rising.
    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
        @(negedge clock);
    endtask

    task automatic drive(input bit r, input bit h, input bit s, input int c);
        run_req    = r;
        halt_req   = h;
        step_req   = s;
        step_count = SW'(c);
        tick();
        run_req  = 1'b0;
        halt_req = 1'b0;
        step_req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        resetn     = 1'b1;
        run_req    = 1'b0;
        halt_req   = 1'b0;
        step_req   = 1'b0;
        step_count = '0;
        @(negedge clock);
        do_reset();

        // Hold sequence with a run_req that must be ignored.
        for (int i = 0; i < int'(RC); i++) begin
            chk("hold_rst_n", 32'(cpu_rst_n), 32'd0);
            if (i == 4) drive(1'b1, 1'b0, 1'b0, 0);
            else tick();
        end
        chk("hold_done_halted", 32'(halted), 32'd1);
        idle(3);

        // Run for ten enabled cycles.
        drive(1'b1, 1'b0, 1'b0, 0);
        idle(9);
        drive(1'b0, 1'b1, 1'b0, 0);
        idle(2);
        chk("run10_cnt", cycle_cnt, 32'd10);

        // Step bursts of 3 and of 0 (treated as 1).
        drive(1'b0, 1'b0, 1'b1, 3);
        idle(5);
        chk("step3_cnt", cycle_cnt, 32'd13);
        drive(1'b0, 1'b0, 1'b1, 0);
        idle(3);
        chk("step0_cnt", cycle_cnt, 32'd14);

        // Long burst aborted after 50 enabled cycles.
        drive(1'b0, 1'b0, 1'b1, 200);
        idle(49);
        drive(1'b0, 1'b1, 1'b0, 0);
        idle(3);
        chk("abort_cnt", cycle_cnt, 32'd64);

        // Request priority in HALTED.
        drive(1'b1, 1'b1, 1'b1, 4);
        chk("prio_all_halted", 32'(state), 32'd1);
        drive(1'b1, 1'b0, 1'b1, 2);
        chk("prio_step_state", 32'(state), 32'd3);
        idle(4);

        // Counter wrap: preload while halted, then run 3 cycles.
        dut.cycle_cnt_q = 32'hFFFF_FFFE;
        m_cnt           = 32'hFFFF_FFFE;
        drive(1'b1, 1'b0, 1'b0, 0);
        idle(2);
        drive(1'b0, 1'b1, 1'b0, 0);
        idle(1);
        chk("wrap_cnt", cycle_cnt, 32'd1);

        // Asynchronous reset mid-RUN, then a full hold again.
        drive(1'b1, 1'b0, 1'b0, 0);
        idle(3);
        resetn = 1'b0;
        #1;
        chk("async_cpu_en", 32'(cpu_en), 32'd0);
        @(negedge clock);
        do_reset();
        idle(int'(RC) - 1);
        chk("rehold_still_low", 32'(cpu_rst_n), 32'd0);
        tick();
        chk("rehold_halted", 32'(halted), 32'd1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
                      $urandom_range(0, 7) == 0, int'($urandom_range(0, 6)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/clock_gate_ctrl.md
CLOCK_GATE_CTRL -- requirements
Module: clock_gate_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_CYCLES, default 16: number of clock cycles cpu_rst_n is held low after reset release (1..65535).
REQ-002 The block SHALL have parameter STEP_W, default 8: width of step_count.
REQ-003 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port resetn, input, 1: asynchronous, active-low reset; assertion acts immediately, release is sampled on the clock.
REQ-005 Port run_req, input, 1: one-cycle pulse requesting free-running execution.
REQ-006 Port halt_req, input, 1: one-cycle pulse requesting halt.
REQ-007 Port step_req, input, 1: one-cycle pulse requesting a step burst while halted.
REQ-008 Port step_count, input, STEP_W: number of enabled cycles per step burst, sampled with step_req.
REQ-009 Port cpu_en, output, 1: clock enable to the CPU core.
REQ-010 Port cpu_rst_n, output, 1: synchronous active-low reset to the CPU core.
REQ-011 Port halted, output, 1: high while in HALTED.
REQ-012 Port step_done, output, 1: one-cycle pulse when a step burst completes normally.
REQ-013 Port state, output, 2: current state encoding; RST_HOLD=0, HALTED=1, RUN=2, STEP=3.
REQ-014 Port cycle_cnt, output, 32: count of cycles with cpu_en=1.

Function
REQ-015 The FSM SHALL have exactly four states: RST_HOLD, HALTED, RUN, STEP.
REQ-016 All outputs SHALL be registered and Moore-decoded from state, except step_done and cycle_cnt, which are registered.
REQ-017 RST_HOLD: a hold counter SHALL count RESET_CYCLES clock edges after resetn release, then go to HALTED; run_req, halt_req and step_req are ignored in this state.
REQ-018 cpu_rst_n SHALL be 0 in RST_HOLD and 1 in all other states.
REQ-019 HALTED -> RUN on run_req; HALTED -> STEP on step_req, loading the burst counter with step_count.
REQ-020 A step_count of 0 SHALL be treated as 1.
REQ-021 In HALTED, priority SHALL be halt_req > step_req > run_req; with halt_req asserted, the FSM stays in HALTED.
REQ-022 RUN -> HALTED on halt_req; run_req and step_req SHALL be ignored in RUN.
REQ-023 STEP SHALL keep cpu_en=1 for exactly N cycles (N = effective step_count), then go to HALTED.
REQ-024 step_done SHALL pulse high for one cycle, coincident with the first HALTED cycle, after a normal STEP completion.
REQ-025 halt_req in STEP SHALL abort the burst: next state HALTED, no step_done pulse, and the remaining count is discarded.
REQ-026 run_req and step_req SHALL be ignored in STEP.
REQ-027 cpu_en SHALL be 1 iff state is RUN or STEP.
REQ-028 Latency: a request sampled at edge k SHALL change state and cpu_en after edge k; the first enabled cycle is k..k+1.
REQ-029 cycle_cnt SHALL increment by 1 on each edge where cpu_en=1.
REQ-030 cycle_cnt SHALL wrap from 0xFFFFFFFF to 0.
REQ-031 cycle_cnt SHALL NOT be cleared by halt or step; only resetn clears it.

Reset
REQ-032 On resetn=0, the block SHALL immediately force: state=RST_HOLD, cpu_en=0, cpu_rst_n=0, halted=0, step_done=0, cycle_cnt=0, hold counter=0, burst counter=0.
REQ-033 resetn asserted mid-RUN or mid-STEP SHALL abort all activity asynchronously; after release, the full RESET_CYCLES hold SHALL repeat.

Verification
REQ-034 Reset release, RESET_CYCLES=16, run_req pulsed at cycle 5 -> cpu_rst_n=0 for 16 cycles, run_req ignored, then state=HALTED and halted=1.
REQ-035 HALTED, run_req pulse at edge k, halt_req pulse at edge k+10 -> cpu_en high for exactly 10 cycles, cycle_cnt=10, halted=1.
REQ-036 HALTED, step_req with step_count=3 -> cpu_en high for exactly 3 cycles, then step_done=1 for 1 cycle, cycle_cnt += 3; repeat with step_count=0 -> 1 cycle.
REQ-037 STEP with step_count=200, halt_req after 50 enabled cycles -> HALTED, step_done stays 0, cycle_cnt += 50.
REQ-038 HALTED with halt_req, step_req and run_req all pulsed together -> stays HALTED, cpu_en=0; step_req and run_req together -> STEP.
REQ-039 cycle_cnt forced near 0xFFFFFFFE, RUN for 3 cycles -> value 1; resetn pulsed low mid-RUN -> cpu_en=0 immediately and the hold sequence restarts.
